// File: rtl/digit_pkg.sv
// Shared widths, bounding-box record and helpers for the digit recognizer front end.
package digit_pkg;
   localparam int COORD_W     = 12;
   localparam int RGB_W       = 24;
   localparam int FRAME_CNT_W = 3;
   localparam int RUN_W       = 4;
   localparam logic [COORD_W-1:0] COORD_INIT_MIN = 12'hFFF;

   typedef struct packed {
      logic [COORD_W-1:0] hl;
      logic [COORD_W-1:0] hr;
      logic [COORD_W-1:0] vl;
      logic [COORD_W-1:0] vr;
   } bbox_t;

   // Empty box: min at the top of the range so the first included pixel wins.
   localparam bbox_t BOX_INIT = '{hl: COORD_INIT_MIN, hr: '0, vl: COORD_INIT_MIN, vr: '0};

   function automatic logic [RUN_W-1:0] sat15(input logic [RUN_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/digit_bbox_detect_fg_run_filter.sv
// Horizontal run-length filter: flags the pixel that completes a MIN_RUN run and every later pixel of it.
module fg_run_filter
   import digit_pkg::*;
#(
   parameter int MIN_RUN = 2
) (
   input  logic               pixelclk,
   input  logic               reset,
   input  logic               fg,
   input  logic [COORD_W-1:0] vcount,
   input  logic               clear,
   output logic               qual_first,
   output logic               qual_cont
);
   localparam logic [RUN_W-1:0] RUN_FIRST = RUN_W'(MIN_RUN - 1);
   localparam logic [RUN_W-1:0] RUN_MIN   = RUN_W'(MIN_RUN);

   logic [RUN_W-1:0]   r_run_cnt;
   logic [COORD_W-1:0] r_last_v;
   logic [RUN_W-1:0]   w_prev;

   // A row change with no blanking in between starts a fresh run.
   always_comb begin
      w_prev = '0;
      if (fg && (vcount == r_last_v))
         w_prev = r_run_cnt;
   end

   assign qual_first = fg & ~clear & (w_prev == RUN_FIRST);
   assign qual_cont  = fg & ~clear & (w_prev >= RUN_MIN);

   always_ff @(posedge pixelclk) begin
      if (reset) begin
         r_run_cnt <= '0;
         r_last_v  <= '0;
      end else begin
         if (clear || !fg)
            r_run_cnt <= '0;
         else
            r_run_cnt <= sat15(w_prev);
         if (fg)
            r_last_v <= vcount;
      end
   end
endmodule

// File: rtl/digit_bbox_detect.sv
// Per-frame foreground bounding box with run-length noise rejection; publishes on each vsync rise.
module digit_bbox_detect
   import digit_pkg::*;
#(
   parameter int MIN_RUN    = 2,
   parameter int MIN_PIXELS = 64,
   parameter int FRAME_DIV  = 4,
   parameter int CNT_W      = 20
) (
   input  logic                   pixelclk,
   input  logic                   reset,
   input  logic [RGB_W-1:0]       i_rgb,
   input  logic                   i_vsync,
   input  logic                   i_de,
   input  logic [COORD_W-1:0]     hcount,
   input  logic [COORD_W-1:0]     vcount,
   output logic [COORD_W-1:0]     hcount_l,
   output logic [COORD_W-1:0]     hcount_r,
   output logic [COORD_W-1:0]     vcount_l,
   output logic [COORD_W-1:0]     vcount_r,
   output logic                   box_valid,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);
   localparam logic [CNT_W:0]         INC_FIRST = (CNT_W+1)'(MIN_RUN);
   localparam logic [CNT_W:0]         INC_ONE   = (CNT_W+1)'(1);
   localparam logic [COORD_W-1:0]     RUN_BACK  = COORD_W'(MIN_RUN - 1);
   localparam logic [FRAME_CNT_W-1:0] FC_LAST   = FRAME_CNT_W'(FRAME_DIV - 1);

   logic                   r_vs_d;
   bbox_t                  r_run;
   bbox_t                  r_pub;
   logic [CNT_W-1:0]       r_pix_cnt;
   logic                   r_box_valid;
   logic [FRAME_CNT_W-1:0] r_frame_cnt;

   logic                   w_fg;
   logic                   w_vs_rise;
   logic                   w_qual_first;
   logic                   w_qual_cont;
   logic                   w_incl;
   logic                   w_pass;
   logic [COORD_W-1:0]     w_lo_h;
   logic [CNT_W:0]         w_sum;
   logic [CNT_W-1:0]       w_pix_next;

   assign w_fg      = i_de & (|i_rgb);
   assign w_vs_rise = i_vsync & ~r_vs_d;

   fg_run_filter #(.MIN_RUN(MIN_RUN)) u_run (
      .pixelclk   (pixelclk),
      .reset      (reset),
      .fg         (w_fg),
      .vcount     (vcount),
      .clear      (w_vs_rise),
      .qual_first (w_qual_first),
      .qual_cont  (w_qual_cont)
   );

   // The first qualifying pixel also accounts for the MIN_RUN-1 pixels before it.
   always_comb begin
      w_incl     = w_qual_first | w_qual_cont;
      w_lo_h     = w_qual_first ? (hcount - RUN_BACK) : hcount;
      w_sum      = {1'b0, r_pix_cnt} + (w_qual_first ? INC_FIRST : INC_ONE);
      w_pix_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      w_pass     = int'(r_pix_cnt) >= MIN_PIXELS;
   end

   always_ff @(posedge pixelclk) begin
      if (reset) begin
         r_vs_d      <= 1'b0;
         r_run       <= BOX_INIT;
         r_pix_cnt   <= '0;
         r_pub       <= '0;
         r_box_valid <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_vs_d <= i_vsync;
         if (w_vs_rise) begin
            if (w_pass) begin
               r_pub       <= r_run;
               r_box_valid <= 1'b1;
            end else begin
               r_box_valid <= 1'b0;
            end
            r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + 1'b1;
            r_run       <= BOX_INIT;
            r_pix_cnt   <= '0;
         end else if (w_incl) begin
            if (w_lo_h < r_run.hl) r_run.hl <= w_lo_h;
            if (hcount > r_run.hr) r_run.hr <= hcount;
            if (vcount < r_run.vl) r_run.vl <= vcount;
            if (vcount > r_run.vr) r_run.vr <= vcount;
            r_pix_cnt <= w_pix_next;
         end
      end
   end

   assign hcount_l  = r_pub.hl;
   assign hcount_r  = r_pub.hr;
   assign vcount_l  = r_pub.vl;
   assign vcount_r  = r_pub.vr;
   assign box_valid = r_box_valid;
   assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_digit_bbox_detect.sv
// Directed bench for digit_bbox_detect: frame-level box model compared every cycle, plus literal anchors.
module tb_digit_bbox_detect;
   localparam int MIN_RUN    = 2;
   localparam int MIN_PIXELS = 64;
   localparam int FRAME_DIV  = 4;
   localparam int CNT_W      = 8;
   localparam int SAT        = (1 << CNT_W) - 1;
   localparam int FC_EXP [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};

   logic        pixelclk = 1'b0;
   logic        reset    = 1'b1;
   logic [23:0] i_rgb    = '0;
   logic        i_vsync  = 1'b0;
   logic        i_de     = 1'b0;
   logic [11:0] hcount   = '0;
   logic [11:0] vcount   = '0;
   logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
   logic        box_valid;
   logic [2:0]  frame_cnt;

   digit_bbox_detect #(
      .MIN_RUN(MIN_RUN), .MIN_PIXELS(MIN_PIXELS), .FRAME_DIV(FRAME_DIV), .CNT_W(CNT_W)
   ) dut (
      .pixelclk(pixelclk), .reset(reset), .i_rgb(i_rgb), .i_vsync(i_vsync), .i_de(i_de),
      .hcount(hcount), .vcount(vcount), .hcount_l(hcount_l), .hcount_r(hcount_r),
      .vcount_l(vcount_l), .vcount_r(vcount_r), .box_valid(box_valid), .frame_cnt(frame_cnt)
   );

   always #5 pixelclk = ~pixelclk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   // model: published outputs and the running frame
   bit m_vs_d;
   int m_hl, m_hr, m_vl, m_vr, m_valid, m_fc;
   int m_minh, m_maxh, m_minv, m_maxv, m_cnt;
   int m_run_n, m_run_v, m_run_h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic frame_clear();
      m_minh = 4095; m_maxh = 0; m_minv = 4095; m_maxv = 0;
      m_cnt = 0; m_run_n = 0;
   endtask

   task automatic include_px(input int h, input int v);
      if (h < m_minh) m_minh = h;
      if (h > m_maxh) m_maxh = h;
      if (v < m_minv) m_minv = v;
      if (v > m_maxv) m_maxv = v;
   endtask

   task automatic add_cnt(input int n);
      m_cnt = (m_cnt + n > SAT) ? SAT : m_cnt + n;
   endtask

   task automatic model_step(input bit rst, input bit de, input logic [23:0] rgb,
                             input int h, input int v, input bit vs);
      bit rise, fg;
      if (rst) begin
         m_vs_d = 0; m_fc = 0; m_valid = 0;
         m_hl = 0; m_hr = 0; m_vl = 0; m_vr = 0;
         frame_clear();
         return;
      end
      rise = vs && !m_vs_d;
      m_vs_d = vs;
      if (rise) begin
         if (m_cnt >= MIN_PIXELS) begin
            m_hl = m_minh; m_hr = m_maxh; m_vl = m_minv; m_vr = m_maxv; m_valid = 1;
         end else begin
            m_valid = 0;
         end
         m_fc = (m_fc + 1) % FRAME_DIV;
         frame_clear();
         return;
      end
      fg = de && (rgb != 0);
      if (!fg) begin
         m_run_n = 0;
         return;
      end
      if (m_run_n > 0 && v != m_run_v) m_run_n = 0;
      if (m_run_n == 0) m_run_h0 = h;
      m_run_n++;
      m_run_v = v;
      if (m_run_n == MIN_RUN) begin
         include_px(m_run_h0, v);
         include_px(h, v);
         add_cnt(MIN_RUN);
      end else if (m_run_n > MIN_RUN) begin
         include_px(h, v);
         add_cnt(1);
      end
   endtask

   task automatic cyc(input bit rst, input bit de, input logic [23:0] rgb,
                      input int h, input int v, input bit vs);
      @(negedge pixelclk);
      reset = rst; i_de = de; i_rgb = rgb; i_vsync = vs;
      hcount = h[11:0]; vcount = v[11:0];
      @(posedge pixelclk);
      model_step(rst, de, rgb, h, v, vs);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 24'h0, 0, 0, 0);
   endtask

   task automatic px(input int h, input int v);
      cyc(0, 1, v[0] ? 24'h000001 : 24'h800000, h, v, 0);
   endtask

   task automatic row(input int c0, input int w, input int v);
      for (int i = 0; i < w; i++) px(c0 + i, v);
      idle(2);
   endtask

   task automatic blk(input int c0, input int w, input int r0, input int hgt);
      for (int r = 0; r < hgt; r++) row(c0, w, r0 + r);
   endtask

   task automatic vsync(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 24'h0, 0, 0, 1);
      idle(3);
   endtask

   task automatic lit(input string tag, input int hl, input int hr, input int vl, input int vr,
                      input int valid, input int fc);
      @(negedge pixelclk);
      chk({tag, "_hl"}, 32'(hcount_l), hl);
      chk({tag, "_hr"}, 32'(hcount_r), hr);
      chk({tag, "_vl"}, 32'(vcount_l), vl);
      chk({tag, "_vr"}, 32'(vcount_r), vr);
      chk({tag, "_valid"}, 32'(box_valid), valid);
      chk({tag, "_fc"}, 32'(frame_cnt), fc);
   endtask

   always @(negedge pixelclk) begin
      if (chk_en) begin
         chk("cyc_hcount_l", 32'(hcount_l), m_hl);
         chk("cyc_hcount_r", 32'(hcount_r), m_hr);
         chk("cyc_vcount_l", 32'(vcount_l), m_vl);
         chk("cyc_vcount_r", 32'(vcount_r), m_vr);
         chk("cyc_box_valid", 32'(box_valid), m_valid);
         chk("cyc_frame_cnt", 32'(frame_cnt), m_fc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc(1, 0, 24'h0, 0, 0, 0);
      cyc(1, 0, 24'h0, 0, 0, 0);
      chk_en = 1;
      lit("reset", 0, 0, 0, 0, 0, 0);
      idle(2);

      // 10x8 block -> published box
      blk(100, 10, 50, 8);
      vsync(1);
      lit("box", 100, 109, 50, 57, 1, 1);

      // isolated pixels, de-low colour, row change without blanking: none qualify
      px(5, 5); idle(2);
      px(300, 200); idle(2);
      for (int i = 0; i < 5; i++) cyc(0, 0, 24'hFFFFFF, 700 + i, 300, 0);
      px(600, 20); px(601, 21); idle(2);
      blk(100, 10, 50, 8);
      vsync(1);
      lit("noise", 100, 109, 50, 57, 1, 2);

      // 56 pixels: below threshold, edges hold
      blk(20, 7, 10, 8);
      vsync(1);
      lit("thresh", 100, 109, 50, 57, 0, 3);

      // run at cols 0..1
      row(0, 2, 3);
      blk(100, 10, 50, 8);
      vsync(1);
      lit("col0", 0, 109, 3, 57, 1, 0);

      // fg on the vsync-rise cycle is dropped and breaks the run
      blk(200, 10, 60, 8);
      px(999, 900);
      cyc(0, 1, 24'h0000FF, 1000, 900, 1);
      cyc(0, 1, 24'h0000FF, 1001, 900, 0);
      idle(3);
      lit("rise_fg_a", 200, 209, 60, 67, 1, 1);
      blk(300, 10, 70, 8);
      vsync(1);
      lit("rise_fg_b", 300, 309, 70, 77, 1, 2);

      // counter saturation: 2^CNT_W+10 pixels in one run
      row(10, (1 << CNT_W) + 10, 7);
      vsync(1);
      lit("sat", 10, 265 + 10, 7, 7, 1, 3);

      // reset mid-frame discards the partial frame
      blk(500, 10, 100, 3);
      cyc(1, 0, 24'h0, 0, 0, 0);
      lit("midrst", 0, 0, 0, 0, 0, 0);
      blk(100, 10, 50, 8);
      vsync(1);
      lit("postrst", 100, 109, 50, 57, 1, 1);

      // frame_cnt sequence from reset; third pulse held high 5 cycles
      cyc(1, 0, 24'h0, 0, 0, 0);
      idle(2);
      for (int k = 0; k < 9; k++) begin
         vsync((k == 2) ? 5 : 1);
         lit($sformatf("fc%0d", k), 0, 0, 0, 0, 0, FC_EXP[k]);
      end

      idle(3);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
